// File: rtl/source_detector.sv
// Gap-length detector: flags 1s separated by 1, 2 or 3 zeros with a registered 2-bit code.
// Build option SOURCE_OVERLAP_EN: when defined, the closing 1 of a detection also opens the next pattern.
//
// state | meaning
// IDLE  | no 1 seen yet, or last pattern consumed
// ONE   | last sampled bit was 1
// Z1    | one zero since the last 1
// Z2    | two zeros since the last 1
// Z3    | three zeros since the last 1
// ZL    | four or more zeros, gap too long to detect
module source_detector (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  output logic [1:0] y
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ONE  = 3'd1,
    Z1   = 3'd2,
    Z2   = 3'd3,
    Z3   = 3'd4,
    ZL   = 3'd5
  } state_t;

`ifdef SOURCE_OVERLAP_EN
  localparam state_t DET_NEXT = ONE;
`else
  localparam state_t DET_NEXT = IDLE;
`endif

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_G1   = 2'b01;
  localparam logic [1:0] CODE_G2   = 2'b10;
  localparam logic [1:0] CODE_G3   = 2'b11;

  state_t     state_q, state_d;
  logic [1:0] y_q, y_d;

  always_comb begin
    state_d = state_q;
    y_d     = CODE_NONE;
    case (state_q)
      IDLE: state_d = x ? ONE : IDLE;
      ONE:  state_d = x ? ONE : Z1;
      Z1: begin
        if (x) begin
          state_d = DET_NEXT;
          y_d     = CODE_G1;
        end else begin
          state_d = Z2;
        end
      end
      Z2: begin
        if (x) begin
          state_d = DET_NEXT;
          y_d     = CODE_G2;
        end else begin
          state_d = Z3;
        end
      end
      Z3: begin
        if (x) begin
          state_d = DET_NEXT;
          y_d     = CODE_G3;
        end else begin
          state_d = ZL;
        end
      end
      ZL:      state_d = x ? ONE : ZL;
      // unused encodings recover to IDLE
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      y_q     <= CODE_NONE;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_source_detector.sv
// Scoreboard bench for source_detector: stimulus pushes the expected y per sampled bit,
// a monitor pops and compares one entry after every rising edge.
module tb_source_detector;

  logic       clk;
  logic       rst;
  logic       x;
  logic [1:0] y;

  int         n_checks;
  int         n_pass;
  logic [1:0] exp_q[$];
  string      tag_q[$];
  string      cur_tag;

  source_detector dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: y=%b expected %b", name, act, req);
  endtask

  // drive one bit (at negedge) and record the y expected after the next rising edge
  task automatic send(input logic b, input logic [1:0] e);
    @(negedge clk);
    x = b;
    exp_q.push_back(e);
    tag_q.push_back(cur_tag);
  endtask

  task automatic sep();
    for (int i = 0; i < 4; i++) send(1'b0, 2'b00);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check(tag_q.pop_front(), y, exp_q.pop_front());
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    x        = 1'b0;
    rst      = 1'b0;
    cur_tag  = "reset";
    #2;
    check("reset_async", y, 2'b00);
    send(1'b1, 2'b00);
    send(1'b0, 2'b00);
    @(negedge clk);
    rst = 1'b1;

    cur_tag = "release_101";
    send(1'b1, 2'b00); send(1'b0, 2'b00); send(1'b1, 2'b01); send(1'b0, 2'b00);
    sep();

    cur_tag = "gap2_1001";
    send(1'b1, 2'b00); send(1'b0, 2'b00); send(1'b0, 2'b00); send(1'b1, 2'b10);
    send(1'b0, 2'b00);
    sep();

    cur_tag = "gap3_10001";
    send(1'b1, 2'b00); send(1'b0, 2'b00); send(1'b0, 2'b00); send(1'b0, 2'b00);
    send(1'b1, 2'b11); send(1'b0, 2'b00);
    sep();

    cur_tag = "ones_no_det";
    for (int i = 0; i < 7; i++) send(1'b1, 2'b00);
    cur_tag = "ones_recover";
    send(1'b1, 2'b00); send(1'b0, 2'b00); send(1'b1, 2'b01); send(1'b0, 2'b00);
    sep();

    cur_tag = "gap4_no_det";
    send(1'b1, 2'b00);
    for (int i = 0; i < 4; i++) send(1'b0, 2'b00);
    send(1'b1, 2'b00);
    cur_tag = "zl_recover";
    send(1'b1, 2'b00); send(1'b0, 2'b00); send(1'b1, 2'b01); send(1'b0, 2'b00);
    sep();

    cur_tag = "overlap_10101";
    send(1'b1, 2'b00); send(1'b0, 2'b00); send(1'b1, 2'b01); send(1'b0, 2'b00);
`ifdef SOURCE_OVERLAP_EN
    send(1'b1, 2'b01);
`else
    send(1'b1, 2'b00);
`endif
    send(1'b0, 2'b00);
    sep();

    cur_tag = "reset_mid";
    send(1'b1, 2'b00); send(1'b0, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    x   = 1'b0;
    exp_q.push_back(2'b00); tag_q.push_back(cur_tag);
    send(1'b0, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    x   = 1'b1;
    exp_q.push_back(2'b00); tag_q.push_back(cur_tag);
    cur_tag = "reset_mid_after";
    send(1'b0, 2'b00); send(1'b1, 2'b01); send(1'b0, 2'b00);
    sep();

    cur_tag = "async_pre";
    send(1'b1, 2'b00); send(1'b0, 2'b00); send(1'b1, 2'b01);
    @(posedge clk);
    #3;
    check("async_before_drop", y, 2'b01);
    rst = 1'b0;
    #1;
    check("async_drop", y, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    x   = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: pending=%0d expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
